// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe: the producer side drives beats
// and out_ready, the adder (slave) returns in_ready and the flagged result.
interface adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    logic             z;
    logic             n;

    modport master (
        output in_valid, a, b, ci, op, out_ready,
        input  in_ready, out_valid, s, co, ov, z, n
    );

    modport slave (
        input  in_valid, a, b, ci, op, out_ready,
        output in_ready, out_valid, s, co, ov, z, n
    );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES registered
// segments and the whole pipe advances as one unit under valid/ready backpressure.
module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    adder_pipe_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    logic [WIDTH-1:0] y_map;
    logic             c0;
    logic             adv;
    logic             out_valid;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        y_map = bus.b;
        c0    = 1'b0;
        case (op_e'(bus.op))
            OP_ADD: c0 = 1'b0;
            OP_SUB: begin
                y_map = ~bus.b;
                c0    = 1'b1;
            end
            OP_ADC: c0 = bus.ci;
            OP_SBB: begin
                y_map = ~bus.b;
                c0    = ~bus.ci;
            end
            default: c0 = 1'b0;
        endcase
    end

    // Stage k consumes the low SEG bits of the operands it receives and forwards the rest.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W  = WIDTH - k * SEG;
        localparam int ACC_W = (k + 1) * SEG;

        logic [IN_W-1:0]  x_in;
        logic [IN_W-1:0]  y_in;
        logic             c_in;
        logic             v_in;
        logic [SEG:0]     seg_sum;
        logic [ACC_W-1:0] acc_next;
        logic [ACC_W-1:0] acc_q;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_head
            assign x_in     = bus.a;
            assign y_in     = y_map;
            assign c_in     = c0;
            assign v_in     = bus.in_valid;
            assign acc_next = seg_sum[SEG-1:0];
        end else begin : g_body
            assign x_in     = g_stage[k-1].g_fwd.x_q;
            assign y_in     = g_stage[k-1].g_fwd.y_q;
            assign c_in     = g_stage[k-1].c_q;
            assign v_in     = g_stage[k-1].v_q;
            assign acc_next = {seg_sum[SEG-1:0], g_stage[k-1].acc_q};
        end

        assign seg_sum = {1'b0, x_in[SEG-1:0]} + {1'b0, y_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

        // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
        // NOTE: data registers are reset along with valid because s/co must read 0 out of reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                acc_q <= '0;
            end else if (adv) begin
                v_q   <= v_in;
                c_q   <= seg_sum[SEG];
                acc_q <= acc_next;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IN_W-SEG-1:0] x_q;
            logic [IN_W-SEG-1:0] y_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_q <= '0;
                    y_q <= '0;
                end else if (adv) begin
                    x_q <= x_in[IN_W-1:SEG];
                    y_q <= y_in[IN_W-1:SEG];
                end
            end
        end else begin : g_tail
            logic ov_q;
            logic z_q;
            logic n_q;

            // The final segment holds the operand MSBs, so the flags are formed here.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ov_q <= 1'b0;
                    z_q  <= 1'b0;
                    n_q  <= 1'b0;
                end else if (adv) begin
                    ov_q <= (x_in[IN_W-1] == y_in[IN_W-1]) && (seg_sum[SEG-1] != x_in[IN_W-1]);
                    z_q  <= (acc_next == '0);
                    n_q  <= seg_sum[SEG-1];
                end
            end
        end
    end

    assign out_valid     = g_stage[STAGES-1].v_q;
    assign adv           = !out_valid || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid;
    assign bus.s         = g_stage[STAGES-1].acc_q;
    assign bus.co        = g_stage[STAGES-1].c_q;
    assign bus.ov        = g_stage[STAGES-1].g_tail.ov_q;
    assign bus.z         = g_stage[STAGES-1].g_tail.z_q;
    assign bus.n         = g_stage[STAGES-1].g_tail.n_q;
endmodule
